// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the cache request path.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      REQ_IDLE,
      REQ_DATA,
      REQ_HALT
   } req_state_t;

endpackage

// File: rtl/req_wait_ctr.sv
// Saturating data-wait counter; hit_max flags the counter's top value.
module req_wait_ctr #(
   parameter int WAIT_W   = 8,
   parameter int MAX_WAIT = 200
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              en,
   input  logic              clr,
   output logic [WAIT_W-1:0] count,
   output logic              hit_max
);

   assign hit_max = (count == '1);

   always_ff @(posedge CLK) begin
      if (!nRST || clr) begin
         count <= '0;
      end else if (en && !hit_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_request_unit.sv
// Registered I/D cache request sequencer with halt drain and error flags.
// Optional perf counters are built when REQ_PERF_EN is defined.
module mem_request_unit
   import cpu_types_pkg::*;
#(
   parameter int WAIT_W   = 8,
   parameter int MAX_WAIT = 200,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             iread,
   input  logic             dread,
   input  logic             dwrite,
   input  logic             datomic_req,
   input  logic             halt,
   input  logic             ihit,
   input  logic             dhit,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             datomic,
   output logic             dpending,
   output logic             timeout_err,
`ifdef REQ_PERF_EN
   output logic             proto_err,
   output logic [CNT_W-1:0] perf_icnt,
   output logic [CNT_W-1:0] perf_dcnt
`else
   output logic             proto_err
`endif
);

   req_state_t        state;
   logic              halt_pend;
   logic              launch;
   logic              in_data;
   logic [WAIT_W-1:0] dwait;
   logic              dwait_sat;

   assign launch  = ihit & (dread | dwrite);
   assign in_data = (state == REQ_DATA);

   req_wait_ctr #(
      .WAIT_W   (WAIT_W),
      .MAX_WAIT (MAX_WAIT)
   ) u_wait (
      .CLK     (CLK),
      .nRST    (nRST),
      .en      (in_data & ~dhit & ~dwait_sat),
      .clr     (~in_data | dhit),
      .count   (dwait),
      .hit_max (dwait_sat)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state       <= REQ_IDLE;
         halt_pend   <= 1'b0;
         imemREN     <= 1'b0;
         dmemREN     <= 1'b0;
         dmemWEN     <= 1'b0;
         datomic     <= 1'b0;
         dpending    <= 1'b0;
         timeout_err <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         unique case (state)
            REQ_IDLE: begin
               if (launch) begin
                  state     <= REQ_DATA;
                  halt_pend <= halt;
                  imemREN   <= 1'b0;
                  dmemWEN   <= dwrite;
                  dmemREN   <= dread & ~dwrite;
                  datomic   <= datomic_req;
                  dpending  <= 1'b1;
                  if (dread && dwrite) proto_err <= 1'b1;
               end else if (halt) begin
                  state   <= REQ_HALT;
                  imemREN <= 1'b0;
               end else begin
                  imemREN <= iread;
               end
            end
            REQ_DATA: begin
               // Timeout only flags; the access stays live until dhit
               if (dwait == WAIT_W'(MAX_WAIT)) timeout_err <= 1'b1;
               if (dhit) begin
                  dmemREN   <= 1'b0;
                  dmemWEN   <= 1'b0;
                  datomic   <= 1'b0;
                  dpending  <= 1'b0;
                  halt_pend <= 1'b0;
                  if (halt || halt_pend) begin
                     state   <= REQ_HALT;
                     imemREN <= 1'b0;
                  end else begin
                     state   <= REQ_IDLE;
                     imemREN <= iread;
                  end
               end
            end
            REQ_HALT: begin
               imemREN  <= 1'b0;
               dmemREN  <= 1'b0;
               dmemWEN  <= 1'b0;
               datomic  <= 1'b0;
               dpending <= 1'b0;
            end
            default: state <= REQ_IDLE;
         endcase
      end
   end

`ifdef REQ_PERF_EN
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         perf_icnt <= '0;
         perf_dcnt <= '0;
      end else begin
         if (ihit && imemREN) perf_icnt <= perf_icnt + 1'b1;
         if (in_data && dhit) perf_dcnt <= perf_dcnt + 1'b1;
      end
   end
`endif

endmodule
